// File: rtl/seq_mult_unit.sv
// Shift-add sequential multiplier, one multiplier bit per clock, signed or unsigned
// per transaction, with valid/ready handshakes on operands and product.
module seq_mult_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   md,
  input  logic [WIDTH-1:0]   mr,
  input  logic               sgn,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH:0]       a_q, a_d;
  logic [WIDTH-1:0]     p_q, p_d;
  logic [WIDTH-1:0]     md_q, md_d;
  logic                 neg_q, neg_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic [WIDTH-1:0]     md_mag, mr_mag;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   full;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      p_q       <= '0;
      md_q      <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      p_q       <= p_d;
      md_q      <= md_d;
      neg_q     <= neg_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    p_d       = p_q;
    md_d      = md_q;
    neg_d     = neg_q;
    product_d = product_q;

    // The most negative value negates to itself, which read unsigned is its magnitude.
    md_mag = (sgn && md[WIDTH-1]) ? -md : md;
    mr_mag = (sgn && mr[WIDTH-1]) ? -mr : mr;
    sum    = a_q + {1'b0, (p_q[0] ? md_q : {WIDTH{1'b0}})};
    full   = {a_q[WIDTH-1:0], p_q};

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          md_d    = md_mag;
          p_d     = mr_mag;
          a_d     = '0;
          cnt_d   = '0;
          neg_d   = sgn & (md[WIDTH-1] ^ mr[WIDTH-1]);
          state_d = RUN;
        end
      end
      RUN: begin
        // Add and shift fused: the sum's carry lands in A's MSB before the shift.
        a_d   = {1'b0, sum[WIDTH:1]};
        p_d   = {sum[0], p_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        product_d = neg_q ? -full : full;
        state_d   = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign product   = product_q;

endmodule

// File: tb/tb_seq_mult_unit.sv
// Directed bench for seq_mult_unit (WIDTH=8) with hand-computed products and timing.
module tb_seq_mult_unit;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   md;
  logic [W-1:0]   mr;
  logic           sgn;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;
  logic           busy;

  int vectors = 0;
  int miscompares = 0;

  seq_mult_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .md        (md),
    .mr        (mr),
    .sgn       (sgn),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Steps until out_valid rises (bounded); returns cycles since the accept edge.
  task automatic wait_out(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      n++;
      if (out_valid === 1'b1) break;
    end
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s, input logic [2*W-1:0] exp);
    int n;
    out_ready = 1'b1;
    md = a; mr = b; sgn = s; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_out(n);
    chk({tag, "_lat"}, n, 9);
    chk({tag, "_prod"}, product, exp);
    step();
    chk({tag, "_idle"}, in_ready, 1);
  endtask

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; md = '0; mr = '0; sgn = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_product", product, 0);

    // 13*11 unsigned with cycle-exact timing
    out_ready = 1'b1; md = 8'd13; mr = 8'd11; sgn = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      step();
      chk($sformatf("t1_busy_c%0d", i), busy, 1);
      chk($sformatf("t1_ov_c%0d", i), out_valid, (i == 9) ? 1 : 0);
    end
    chk("t1_prod", product, 16'h008F);
    step();
    chk("t1_ov_fall", out_valid, 0);
    chk("t1_in_ready", in_ready, 1);
    chk("t1_prod_keep", product, 16'h008F);

    do_op("s_min_sq", 8'h80, 8'h80, 1'b1, 16'h4000);
    do_op("s_m3x5", 8'hFD, 8'h05, 1'b1, 16'hFFF1);
    do_op("u_max", 8'hFF, 8'hFF, 1'b0, 16'hFE01);
    do_op("s_m1sq", 8'hFF, 8'hFF, 1'b1, 16'h0001);
    do_op("u_zero", 8'h00, 8'hA5, 1'b0, 16'h0000);
    do_op("s_zero", 8'h9C, 8'h00, 1'b1, 16'h0000);
    do_op("s_127xm128", 8'h7F, 8'h80, 1'b1, 16'hC080);

    // Backpressure: 5*7 held while in_valid pulses
    out_ready = 1'b0; md = 8'd5; mr = 8'd7; sgn = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_out(n);
    chk("bp_lat", n, 9);
    chk("bp_prod", product, 16'h0023);
    md = 8'd2; mr = 8'd2;
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0] ? 1'b0 : 1'b1;
      step();
      chk($sformatf("bp_hold_prod%0d", i), product, 16'h0023);
      chk($sformatf("bp_hold_ready%0d", i), in_ready, 0);
      chk($sformatf("bp_hold_ov%0d", i), out_valid, 1);
    end
    in_valid = 1'b1; out_ready = 1'b1;
    step();
    chk("bp_ret_idle", in_ready, 1);
    chk("bp_ret_ov", out_valid, 0);
    chk("bp_ret_prod", product, 16'h0023);
    step();
    in_valid = 1'b0;
    chk("bp_acc2_busy", busy, 1);
    chk("bp_acc2_ready", in_ready, 0);
    wait_out(n);
    chk("bp2_lat", n, 9);
    chk("bp2_prod", product, 16'h0004);
    step();

    // Reset on the 4th RUN cycle
    md = 8'd15; mr = 8'd15; sgn = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_product", product, 0);
    do_op("post_rst_7x6", 8'd7, 8'd6, 1'b0, 16'h002A);

    // Back-to-back with in_valid held high
    out_ready = 1'b1; md = 8'd200; mr = 8'd3; sgn = 1'b0; in_valid = 1'b1;
    step();
    md = 8'hFF; mr = 8'hFF; sgn = 1'b1;
    wait_out(n);
    chk("b2b1_lat", n, 9);
    chk("b2b1_prod", product, 16'h0258);
    step();
    chk("b2b_idle", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("b2b2_acc", busy, 1);
    wait_out(n);
    chk("b2b2_lat", n, 9);
    chk("b2b2_prod", product, 16'h0001);
    step();
    chk("b2b_end_idle", in_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
